bitstream_word_packer: RTL
==========================

# bitstream_word_packer

Packs the byte-granular output of `set_bit` into 32-bit big-endian words and buffers them in a word FIFO for the slice output memory. It sits directly downstream of `set_bit` in the ProRes encoder top.
- Tracks the number of payload bytes per slice for the slice header.
- Provides a valid/ready handshake towards the consumer.
- Flags overflow, because `set_bit` has no backpressure.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: number of 32-bit word entries; must be a power of two, ≥ 4.

Ports (name, direction, width, meaning):
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_byte_count`  in  4  number of valid bytes this cycle, 0–8 (`set_bit` `output_enable_byte`).
- `in_val`  in  64  bytes, MSB-first; byte 0 = `in_val[63:56]`.
- `in_flush`  in  1  zero-pad the partial word and push it.
- `slice_start`  in  1  clears `slice_byte_count` and `overflow`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head on a cycle where `out_valid && out_ready`.
- `out_data`  out  32  head word; the first byte is in `[31:24]`.
- `out_last`  out  1  head word was produced by a flush.
- `fifo_level`  out  log2(FIFO_DEPTH)+1  number of occupied entries.
- `slice_byte_count`  out  32  payload bytes accepted since `slice_start`; pad bytes are excluded.
- `overflow`  out  1  sticky error flag.

## Operation
- **Staging register.** Holds 0–3 leftover bytes plus a 2-bit count `stage_cnt`.
- **Merge.** Each cycle the new bytes are concatenated behind the staged bytes, giving `n = stage_cnt + in_byte_count` (at most 11).
  - `n/4` full words (0, 1 or 2) are pushed to the FIFO in byte order.
  - `n%4` bytes remain staged.
- **Flush.** When `in_flush` is high, this cycle's bytes are merged first. If bytes then remain staged, they are zero-padded into one extra word with `out_last=1`. A flush with nothing staged marks the last full word pushed this cycle as `out_last`; with no word pushed at all, it is a no-op. `stage_cnt` becomes 0.
- **Push limit.** At most 3 words are pushed per cycle (2 full + 1 flush pad). The FIFO therefore has 1 read port and 3 write ports.
- **Overflow.** A cycle is dropped when:
  - `in_byte_count` is greater than 8, or
  - the words required exceed the free entries (`FIFO_DEPTH - fifo_level`, plus 1 if a pop happens the same cycle).

  A dropped cycle pushes nothing, leaves staging and byte count unchanged, and sets `overflow`.
- **Byte count.** `slice_byte_count += in_byte_count` for accepted cycles, wrapping modulo 2^32.
  - When `slice_start` is high, the count is loaded with this cycle's accepted `in_byte_count` instead of being incremented.
  - `overflow` clears, then re-sets if this cycle overflows.
  - `slice_start` does not clear staging or the FIFO; slices are separated by `in_flush`.
- **Simultaneous push and pop.** Both take effect in the same cycle; `fifo_level` changes by pushes − pop.

## Timing
- **Reset values.** All outputs are 0 while `reset` is high: `out_valid`, `out_data`, `out_last`, `fifo_level`, `slice_byte_count`, `overflow`. The staging register and FIFO pointers are also cleared.
- **Reset mid-stream.** Discards all staged bytes and buffered words with no flush.
- **Latency.** A word completed by the input at edge k appears with `out_valid=1` after edge k, i.e. 1 cycle input-to-output when the FIFO was empty.
- **Ordering.** Words leave in strict byte order.
- **Registered outputs.** `out_data` and `out_last` are registered FIFO-head outputs. They hold stable while `out_valid && !out_ready`.
- **Other counters.** `slice_byte_count` and `fifo_level` update on the same edge as the accepted input.

## Structure
- **Shared package.** Add to the shared ProRes package (alongside `prores_param.v` constants):
  - `BYTES_PER_WORD=4`
  - `SB_MAX_BYTES=8`
  - a typedef for the `{data[31:0], last}` FIFO entry.
- **Sub-module.** One sub-module, `word_fifo_3w1r`: a multi-write, single-read circular FIFO with entry count, no overflow protection, and writes qualified by the parent.
- **Top-level placement.** Instantiated next to `set_bit`. Its input is driven from `output_enable_byte`/`output_val`.

## Test plan
1. **Single word.** Reset, then `in_byte_count=4`, `in_val=64'hDEADBEEF_xxxxxxxx` → 1 cycle later `out_data=32'hDEADBEEF`, `out_last=0`, `slice_byte_count=4`.
2. **Carry-over.** Inputs 3 bytes `AA BB CC`, then 6 bytes `11 22 33 44 55 66`, then flush → words `AABBCC11`, `22334455`, then `66000000` with `out_last=1`; `slice_byte_count=9`.
3. **Backpressure and overflow.** With `out_ready=0`, feed 8 bytes per cycle with `FIFO_DEPTH=16` → 8 cycles accepted, `fifo_level=16`. The 9th cycle sets `overflow=1`, the level stays 16, and draining returns the first 16 words in order.
4. **Protocol error.** `in_byte_count=9` → nothing pushed, `overflow=1`. A subsequent `slice_start` clears `overflow` and loads `slice_byte_count` with that cycle's count.
5. **Simultaneous events and reset.** FIFO at 15 entries, a pop in the same cycle as a 2-word push → accepted, level 16. Assert `reset` mid-stream with 2 staged bytes → all outputs 0, and the next 4-byte input yields exactly one word containing only the new bytes.

Source files
------------

// File: rtl/bitstream_word_packer_pkg.sv
// Shared constants and types for the ProRes bitstream word packer.
package bitstream_word_packer_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned SB_MAX_BYTES   = 8;
  localparam int unsigned MAX_PUSH       = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_entry_t;

endpackage

// File: rtl/bitstream_word_packer_word_fifo.sv
// Circular word FIFO with three packed write slots and one read port.
// The parent guarantees that pushes never exceed the free space.
module word_fifo_3w1r
  import bitstream_word_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [1:0]                        i_push_cnt,
  input  word_entry_t [MAX_PUSH-1:0]        i_wr_data,
  input  logic                              i_pop,
  output logic                              o_valid,
  output word_entry_t                       o_head,
  output logic [$clog2(DEPTH):0]            o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  word_entry_t    r_mem [DEPTH];
  word_entry_t    r_head;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [LW-1:0]  r_level;

  logic [AW-1:0]  w_widx [MAX_PUSH];
  logic [AW-1:0]  w_rd_next;
  logic [LW-1:0]  w_lvl_after_pop;
  word_entry_t    w_head_next;

  always_comb begin
    for (int unsigned i = 0; i < MAX_PUSH; i++) begin
      w_widx[i] = r_wr_ptr + AW'(i);
    end
  end

  // Head is re-registered each cycle; a write into an empty FIFO
  // (after this cycle's pop) bypasses straight into the head register.
  always_comb begin
    w_lvl_after_pop = r_level - LW'(i_pop);
    w_rd_next       = r_rd_ptr + AW'(i_pop);
    w_head_next     = '0;
    if (w_lvl_after_pop != '0) begin
      w_head_next = r_mem[w_rd_next];
    end else if (i_push_cnt != 2'd0) begin
      w_head_next = i_wr_data[0];
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < MAX_PUSH; i++) begin
      if (i < 32'(i_push_cnt)) begin
        r_mem[w_widx[i]] <= i_wr_data[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_push_cnt);
      r_rd_ptr <= w_rd_next;
      r_level  <= r_level + LW'(i_push_cnt) - LW'(i_pop);
      r_head   <= w_head_next;
    end
  end

  assign o_valid = (r_level != '0);
  assign o_head  = r_head;
  assign o_level = r_level;

endmodule

// File: rtl/bitstream_word_packer.sv
// Packs byte-granular set_bit output into 32-bit big-endian words,
// buffers them in a word FIFO and tracks per-slice payload bytes.
module bitstream_word_packer
  import bitstream_word_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [3:0]                    in_byte_count,
  input  logic [63:0]                   in_val,
  input  logic                          in_flush,
  input  logic                          slice_start,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   slice_byte_count,
  output logic                          overflow
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [23:0]  r_stage;
  logic [1:0]   r_stage_cnt;
  logic [31:0]  r_byte_cnt;
  logic         r_overflow;

  logic [63:0]  w_in_masked;
  logic [95:0]  w_cat;
  logic [3:0]   w_n;
  logic [1:0]   w_full;
  logic [1:0]   w_rem;
  logic [1:0]   w_total;
  logic [1:0]   w_push_cnt;
  logic [23:0]  w_stage_next;
  logic         w_bad_cnt;
  logic         w_pop;
  logic         w_drop;
  logic         w_accept;
  logic [LW:0]  w_free;
  logic         w_valid;
  logic [LW-1:0] w_level;
  word_entry_t  w_head;
  word_entry_t [MAX_PUSH-1:0] w_wr_data;

  // Staged bytes sit at the top of a 12-byte window and the masked new
  // bytes are shifted in behind them; bytes beyond n stay zero, which
  // gives the flush padding for free.
  always_comb begin
    w_in_masked = in_val & ~({64{1'b1}} >> {in_byte_count, 3'b000});
    w_cat       = {r_stage, 72'b0} | ({w_in_masked, 32'b0} >> {r_stage_cnt, 3'b000});
    w_n         = {2'b00, r_stage_cnt} + in_byte_count;
    w_full      = 2'(w_n / 4'(BYTES_PER_WORD));
    w_rem       = w_n[1:0];
    w_total     = w_full + 2'(in_flush && (w_rem != 2'd0));
    w_bad_cnt   = (in_byte_count > 4'(SB_MAX_BYTES));
    w_pop       = w_valid & out_ready;
    w_free      = (LW+1)'(FIFO_DEPTH) - (LW+1)'(w_level) + (LW+1)'(w_pop);
    w_drop      = w_bad_cnt || ((LW+1)'(w_total) > w_free);
    w_accept    = !w_drop;
    w_push_cnt  = w_accept ? w_total : 2'd0;

    for (int unsigned i = 0; i < MAX_PUSH; i++) begin
      w_wr_data[i].data = w_cat[(95 - 32*i) -: 32];
      w_wr_data[i].last = in_flush && (w_total == 2'(i + 1));
    end

    case (w_full)
      2'd0:    w_stage_next = w_cat[95:72];
      2'd1:    w_stage_next = w_cat[63:40];
      default: w_stage_next = w_cat[31:8];
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stage     <= '0;
      r_stage_cnt <= '0;
      r_byte_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (in_flush) begin
          r_stage     <= '0;
          r_stage_cnt <= '0;
        end else begin
          r_stage     <= w_stage_next;
          r_stage_cnt <= w_rem;
        end
      end
      if (slice_start) begin
        r_byte_cnt <= w_accept ? 32'(in_byte_count) : '0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 32'(in_byte_count);
      end
      r_overflow <= w_drop | (r_overflow & ~slice_start);
    end
  end

  word_fifo_3w1r #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push_cnt (w_push_cnt),
    .i_wr_data  (w_wr_data),
    .i_pop      (w_pop),
    .o_valid    (w_valid),
    .o_head     (w_head),
    .o_level    (w_level)
  );

  assign out_valid        = w_valid;
  assign out_data         = w_head.data;
  assign out_last         = w_head.last;
  assign fifo_level       = w_level;
  assign slice_byte_count = r_byte_cnt;
  assign overflow         = r_overflow;

endmodule
